// File: rtl/load_store_unit.sv
`timescale 1ns / 1ps
// load_store_unit: executes one RV64 load or store over a 32-bit bus.
// Doublewords take two bus beats; narrow loads are sign/zero-extended.

module load_store_unit #(
    parameter int XLEN   = 64,
    parameter int BUS_AW = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              memWrite,
    input  logic [2:0]        memType,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   writeData,
    output logic              stall,
    output logic              done,
    output logic [XLEN-1:0]   readData,
    output logic              accessError,
    output logic              busReq,
    output logic              busWe,
    output logic [BUS_AW-1:0] busAddr,
    output logic [31:0]       busWdata,
    output logic [3:0]        busBe,
    input  logic              busGnt,
    input  logic              busRvalid,
    input  logic [31:0]       busRdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_WAIT0,
        S_REQ1,
        S_WAIT1,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        type_q, type_d;
    logic [BUS_AW-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [31:0]       lo_q, lo_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic [BUS_AW-1:0] word_addr;
    logic              is_dword;

    // Address bits above the bus width never reach the bus.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[XLEN-1:BUS_AW];

    function automatic logic illegal(
        input logic       we,
        input logic [2:0] t,
        input logic [2:0] a
    );
        logic bad;
        bad = (t == 3'b111) || (we && t[2]);
        case (t[1:0])
            2'b01:   bad = bad | a[0];
            2'b10:   bad = bad | (|a[1:0]);
            2'b11:   bad = bad | (|a[2:0]);
            default: bad = bad;
        endcase
        return bad;
    endfunction

    function automatic logic [XLEN-1:0] extend(
        input logic [2:0]  t,
        input logic [1:0]  a,
        input logic [31:0] w
    );
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (t)
            3'b000:  r = {{(XLEN-8){b[7]}}, b};
            3'b001:  r = {{(XLEN-16){h[15]}}, h};
            3'b010:  r = {{(XLEN-32){w[31]}}, w};
            3'b100:  r = {{(XLEN-8){1'b0}}, b};
            3'b101:  r = {{(XLEN-16){1'b0}}, h};
            3'b110:  r = {{(XLEN-32){1'b0}}, w};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign word_addr = {addr_q[BUS_AW-1:2], 2'b00};
    assign is_dword  = (type_q[1:0] == 2'b11);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            type_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            lo_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        type_d  = type_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        lo_d    = lo_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    we_d    = memWrite;
                    type_d  = memType;
                    addr_d  = addr[BUS_AW-1:0];
                    wdata_d = writeData;
                    err_d   = illegal(memWrite, memType, addr[2:0]);
                    state_d = err_d ? S_DONE : S_REQ0;
                end
            end
            S_REQ0: begin
                if (busGnt) begin
                    if (!we_q) begin
                        state_d = S_WAIT0;
                    end else begin
                        state_d = is_dword ? S_REQ1 : S_DONE;
                    end
                end
            end
            S_WAIT0: begin
                if (busRvalid) begin
                    lo_d = busRdata;
                    if (is_dword) begin
                        state_d = S_REQ1;
                    end else begin
                        rdata_d = extend(type_q, addr_q[1:0], busRdata);
                        state_d = S_DONE;
                    end
                end
            end
            S_REQ1: begin
                if (busGnt) begin
                    state_d = we_q ? S_DONE : S_WAIT1;
                end
            end
            S_WAIT1: begin
                if (busRvalid) begin
                    rdata_d = XLEN'({busRdata, lo_q});
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus drive depends only on registered state, so it holds while ungranted.
    always_comb begin
        busReq   = 1'b0;
        busWe    = 1'b0;
        busAddr  = '0;
        busWdata = '0;
        busBe    = '0;
        if (state_q == S_REQ0 || state_q == S_REQ1) begin
            busReq  = 1'b1;
            busWe   = we_q;
            busAddr = (state_q == S_REQ1) ? word_addr + BUS_AW'(4)
                                          : word_addr;
            if (we_q) begin
                unique case (type_q[1:0])
                    2'b00: begin
                        busBe    = 4'b0001 << addr_q[1:0];
                        busWdata = {4{wdata_q[7:0]}};
                    end
                    2'b01: begin
                        busBe    = addr_q[1] ? 4'b1100 : 4'b0011;
                        busWdata = {2{wdata_q[15:0]}};
                    end
                    2'b10: begin
                        busBe    = 4'b1111;
                        busWdata = wdata_q[31:0];
                    end
                    2'b11: begin
                        busBe    = 4'b1111;
                        busWdata = (state_q == S_REQ1) ? wdata_q[63:32]
                                                       : wdata_q[31:0];
                    end
                endcase
            end
        end
    end

    assign stall       = (start && state_q == S_IDLE)
                       || !(state_q == S_IDLE || state_q == S_DONE);
    assign done        = (state_q == S_DONE);
    assign accessError = done && err_q;
    assign readData    = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns / 1ps
// Bench for load_store_unit: byte-addressed memory slave plus a
// reference model that computes loads/stores from plain byte arithmetic.

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        memWrite = 1'b0;
    logic [2:0]  memType = 3'b000;
    logic [63:0] addr = '0;
    logic [63:0] writeData = '0;
    logic        stall, done, accessError, busReq, busWe;
    logic [63:0] readData;
    logic [31:0] busAddr, busWdata;
    logic [3:0]  busBe;
    logic        busGnt = 1'b0;
    logic        busRvalid = 1'b0;
    logic [31:0] busRdata = '0;

    load_store_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .memWrite   (memWrite),
        .memType    (memType),
        .addr       (addr),
        .writeData  (writeData),
        .stall      (stall),
        .done       (done),
        .readData   (readData),
        .accessError(accessError),
        .busReq     (busReq),
        .busWe      (busWe),
        .busAddr    (busAddr),
        .busWdata   (busWdata),
        .busBe      (busBe),
        .busGnt     (busGnt),
        .busRvalid  (busRvalid),
        .busRdata   (busRdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [7:0] bus_mem [int unsigned];
    logic [7:0] ref_mem [int unsigned];

    function automatic logic [7:0] dflt(input int unsigned a);
        return 8'((a * 37) + 11);
    endfunction

    function automatic logic [7:0] bget(input int unsigned a);
        return bus_mem.exists(a) ? bus_mem[a] : dflt(a);
    endfunction

    function automatic logic [7:0] rget(input int unsigned a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic void preload(input int unsigned a,
                                    input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            bus_mem[a + i] = w[8*i +: 8];
            ref_mem[a + i] = w[8*i +: 8];
        end
    endfunction

    function automatic int sz(input logic [2:0] t);
        return 1 << t[1:0];
    endfunction

    function automatic bit bad_req(input logic we, input logic [2:0] t,
                                   input logic [63:0] a);
        return (t == 3'b111) || (we && t[2])
            || ((int'(a[2:0]) % sz(t)) != 0);
    endfunction

    function automatic logic [63:0] ref_load(input logic [2:0] t,
                                             input logic [63:0] a);
        logic [63:0] v;
        int n;
        n = sz(t);
        v = '0;
        for (int i = 0; i < n; i++)
            v = v | (64'(rget(a[31:0] + i)) << (8 * i));
        if (!t[2] && n < 8 && v[8*n-1])
            v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v;
    endfunction

    typedef struct packed {
        logic [31:0] a;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
    } beat_t;

    beat_t       log_q[$];
    int          gnt_delay = 0;
    int          rv_delay = 1;
    int          wait_cnt = 0;
    int          rv_cnt = 0;
    logic [31:0] rv_addr = '0;

    // Memory slave: grants after gnt_delay waiting cycles, returns read
    // data rv_delay cycles after the grant, and injects stray pulses.
    always @(negedge clk) begin
        busGnt    = 1'b0;
        busRvalid = 1'b0;
        if (reset) begin
            wait_cnt = 0;
            rv_cnt   = 0;
        end else begin
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    busRvalid = 1'b1;
                    for (int i = 0; i < 4; i++)
                        busRdata[8*i +: 8] = bget(rv_addr + i);
                end
            end else begin
                busRvalid = ($urandom_range(0, 3) == 0);
                busRdata  = $urandom;
            end
            if (busReq) begin
                if (wait_cnt >= gnt_delay) begin
                    busGnt   = 1'b1;
                    wait_cnt = 0;
                    log_q.push_back('{busAddr, busWe, busBe, busWdata});
                    if (busWe) begin
                        for (int i = 0; i < 4; i++)
                            if (busBe[i])
                                bus_mem[busAddr + i] = busWdata[8*i +: 8];
                    end else begin
                        rv_cnt  = rv_delay;
                        rv_addr = busAddr;
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                busGnt   = ($urandom_range(0, 3) == 0);
            end
        end
    end

    task automatic run(input string tag, input logic we,
                       input logic [2:0] t, input logic [63:0] a,
                       input logic [63:0] wd, input int gd, input int rvd);
        bit          bad;
        int          lat, lat_exp, n_exp;
        logic [63:0] rd_exp, m_bus, m_ref;
        logic        saw_req, pv_req, pv_gnt;
        logic [31:0] pv_a, pv_wd;
        logic [4:0]  pv_bw;
        bad    = bad_req(we, t, a);
        rd_exp = ref_load(t, a);
        if (!bad && we)
            for (int i = 0; i < sz(t); i++)
                ref_mem[a[31:0] + i] = wd[8*i +: 8];
        if (bad)
            lat_exp = 1;
        else if (we)
            lat_exp = (t[1:0] == 2'b11) ? 3 + 2 * gd : 2 + gd;
        else
            lat_exp = (t[1:0] == 2'b11) ? 3 + 2 * (gd + rvd) : 2 + gd + rvd;
        n_exp = bad ? 0 : ((t[1:0] == 2'b11) ? 2 : 1);
        gnt_delay = gd;
        rv_delay  = rvd;
        log_q.delete();
        @(negedge clk);
        start = 1'b1; memWrite = we; memType = t;
        addr = a; writeData = wd;
        #1 chk({tag, ":stall_at_start"}, 64'(stall), 64'd1);
        lat = 0; saw_req = 0; pv_req = 0; pv_gnt = 0;
        pv_a = '0; pv_wd = '0; pv_bw = '0;
        do begin
            @(negedge clk);
            start     = 1'($urandom_range(0, 1));
            memWrite  = 1'($urandom_range(0, 1));
            memType   = 3'($urandom_range(0, 7));
            addr      = {$urandom, $urandom};
            writeData = {$urandom, $urandom};
            #1;
            lat++;
            if (busReq) saw_req = 1;
            if (pv_req && !pv_gnt && busReq) begin
                chk({tag, ":hold_addr_data"}, {busAddr, busWdata},
                    {pv_a, pv_wd});
                chk({tag, ":hold_be_we"}, 64'({busBe, busWe}),
                    64'(pv_bw));
            end
            if (!done)
                chk({tag, ":stall_busy"}, 64'(stall), 64'd1);
            pv_req = busReq; pv_gnt = busGnt;
            pv_a = busAddr; pv_wd = busWdata; pv_bw = {busBe, busWe};
        end while (!done && lat < 80);
        chk({tag, ":latency"}, 64'(lat), 64'(lat_exp));
        chk({tag, ":stall_done"}, 64'(stall), 64'd0);
        chk({tag, ":error"}, 64'(accessError), 64'(bad));
        if (!bad && !we) chk({tag, ":rdata"}, readData, rd_exp);
        if (bad) chk({tag, ":no_bus"}, 64'(saw_req), 64'd0);
        chk({tag, ":beats"}, 64'(log_q.size()), 64'(n_exp));
        for (int k = 0; k < log_q.size(); k++) begin
            chk({tag, ":beat_addr"}, 64'(log_q[k].a),
                64'({a[31:2], 2'b00} + 32'(4 * k)));
            chk({tag, ":beat_we"}, 64'(log_q[k].we), 64'(we));
            if (!we) chk({tag, ":load_be"}, 64'(log_q[k].be), 64'd0);
        end
        if (!bad && we) begin
            for (int i = 0; i < 8; i++) begin
                m_bus[8*i +: 8] = bget({a[31:3], 3'b000} + i);
                m_ref[8*i +: 8] = rget({a[31:3], 3'b000} + i);
            end
            chk({tag, ":mem"}, m_bus, m_ref);
        end
        // A start during DONE must not be accepted.
        start = 1'b1; memWrite = 1'b0; memType = 3'b010; addr = '0;
        @(negedge clk);
        start = 1'b0;
        #1 chk({tag, ":ghost_ignored"}, 64'({stall, done, busReq}), 64'd0);
        if (!bad && !we) chk({tag, ":rdata_held"}, readData, rd_exp);
    endtask

    initial begin
        #1;
        chk("reset_ctrl", 64'({stall, done, accessError, busReq, busWe}),
            64'd0);
        chk("reset_bus", {busAddr, busWdata}, 64'd0);
        chk("reset_be", 64'(busBe), 64'd0);
        chk("reset_rdata", readData, 64'd0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;

        preload(32'h1000, 32'h80AA_BBCC);
        run("ld_b", 0, 3'b000, 64'h1003, '0, 0, 1);
        chk("ld_b_value", readData, 64'hFFFF_FFFF_FFFF_FF80);
        run("ld_bu", 0, 3'b100, 64'h1003, '0, 0, 1);
        chk("ld_bu_value", readData, 64'h80);
        preload(32'h1000, 32'h8001_0000);
        run("ld_hu", 0, 3'b101, 64'h1002, '0, 0, 1);
        chk("ld_hu_value", readData, 64'h8001);

        run("st_d", 1, 3'b011, 64'h2000, 64'h1122_3344_5566_7788, 0, 1);
        if (log_q.size() == 2) begin
            chk("st_d_beat0", 64'(log_q[0]),
                64'({32'h2000, 1'b1, 4'hF, 32'h5566_7788}));
            chk("st_d_beat1", 64'(log_q[1]),
                64'({32'h2004, 1'b1, 4'hF, 32'h1122_3344}));
        end
        run("st_h", 1, 3'b001, 64'h3002, 64'hABCD, 0, 1);
        if (log_q.size() == 1) begin
            chk("st_h_be", 64'(log_q[0].be), 64'hC);
            chk("st_h_wdata", 64'(log_q[0].wd), 64'hABCD_ABCD);
        end

        run("ld_w_mis", 0, 3'b010, 64'h4002, '0, 0, 1);
        run("type7", 0, 3'b111, 64'h4000, '0, 0, 1);
        run("st_bu", 1, 3'b100, 64'h4000, '0, 0, 1);

        run("ld_d_slow", 0, 3'b011, 64'h2000, '0, 3, 2);
        chk("ld_d_value", readData, 64'h1122_3344_5566_7788);

        // Reset while the second load beat is outstanding.
        gnt_delay = 3; rv_delay = 2;
        log_q.delete();
        @(negedge clk);
        start = 1'b1; memWrite = 1'b0; memType = 3'b011; addr = 64'h2000;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 chk("rst_in_wait1", 64'({stall, busReq}), 64'b10);
        chk("rst_beats", 64'(log_q.size()), 64'd2);
        reset = 1'b1;
        #1 chk("rst_async", 64'({stall, done, busReq}), 64'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1 chk("rst_no_done", 64'({done, stall}), 64'd0);
        end
        run("after_rst", 0, 3'b010, 64'h2004, '0, 0, 1);
        chk("after_rst_value", readData, 64'h1122_3344);

        for (int n = 0; n < 150; n++) begin
            logic [2:0]  t;
            logic [63:0] a;
            t = 3'($urandom_range(0, 7));
            a = 64'(32'h5000 + $urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0)
                a = a & ~64'(sz(t) - 1);
            run("rand", 1'($urandom_range(0, 1)), t, a,
                {$urandom, $urandom}, $urandom_range(0, 3),
                $urandom_range(1, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
